bcd_7seg_scan: RTL and testbench
================================

// Module: bcd_7seg_scan
// PURPOSE
//  Consumes the two BCD digits (tens, units) produced by the 00-99 BCD counter.
//  Drives a time-multiplexed 2-digit common-anode 7-segment display.
//  Contains a refresh prescaler, a 2-state digit scanner and a frame-coherent input snapshot.
//  Adds inter-digit anti-ghost blanking, optional leading-zero blanking and sticky invalid-digit detection.
// PARAMETERS
//  REFRESH_DIV    50000  clk cycles per digit slot; legal range 2..2**CNT_W
//  CNT_W          16     prescaler counter width
//  BLANK_CYC      1      cycles at slot start with all anodes off; legal range 0..REFRESH_DIV-1
//  SEG_ACT_LOW    1      1: seg pins active-low; 0: active-high
//  AN_ACT_LOW     1      1: an pins active-low; 0: active-high
// PORTS
//  clk       in   1  single clock, all state on posedge
//  rst       in   1  synchronous, active-high reset
//  en        in   1  display enable; 0 = dark, scan frozen
//  bcd0      in   4  units digit from BCD counter (count0)
//  bcd1      in   4  tens digit from BCD counter (count1)
//  blank_lz  in   1  1 = suppress tens digit when it is 0
//  seg       out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  an        out  2  anode enables, an[0]=units, an[1]=tens, polarity per AN_ACT_LOW
//  err       out  1  sticky: a latched digit was >9
// BEHAVIOUR
//  - Reset (dominates en): div_cnt=0, state=DIG0, snapshot={0,0}, blank_lz snapshot=0, err=0.
//    Outputs at reset: seg all inactive (7'h7F when SEG_ACT_LOW), an all inactive (2'b11 when AN_ACT_LOW).
//  - Prescaler, while en=1: div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
//    Tick = en && div_cnt==REFRESH_DIV-1.
//  - Scanner FSM: DIG0 (units) <-> DIG1 (tens); toggles on the edge where tick is high.
//  - Snapshot: on a tick edge that enters DIG0 (frame start), latch bcd1, bcd0 and blank_lz.
//    Mid-frame input changes are never displayed. Display shows 00 until the first frame start after reset.
//  - en=0: div_cnt, state and snapshot hold. Next cycle: seg and an inactive.
//    On re-enable, counting resumes from the held div_cnt.
//  - Outputs are registered from current (state, div_cnt, snapshot, en), so they lag the internal state by 1 clk.
//  - Logical segment encoding (1 = lit):
//    0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; values 10-15 map to 40 ("-").
//    When SEG_ACT_LOW, seg = ~logical.
//  - Anode is active only when div_cnt>=BLANK_CYC. The anode selected is the one for the current state.
//  - Tens anode is suppressed in DIG1 when the blank_lz snapshot=1 and the tens snapshot=0.
//  - While an anode is inactive, seg is forced inactive as well.
//  - err: set on the clock after a snapshot in which either digit >9. It stays set until rst.
//  - Boundaries:
//    - div_cnt wrap and state toggle happen on the same edge.
//    - rst and tick on the same edge: reset wins.
//    - en falling on a tick cycle: no toggle and no snapshot.
// TESTING (bench params REFRESH_DIV=4, BLANK_CYC=1, both polarities active-low)
//  1. Reset: rst=1 for 2 clk -> seg=7'h7F, an=2'b11, err=0. Release rst -> 00 shown once scanning starts.
//  2. bcd1=4, bcd0=2, en=1, after a frame start:
//     - DIG0 slot: 1 clk an=11, then 3 clk an=10, seg=7'h24.
//     - DIG1 slot: 1 clk an=11, then 3 clk an=01, seg=7'h19.
//  3. Frame coherence: change bcd0 2->5 during a DIG1 slot -> DIG1 unchanged; units shows 7'h12 only from the next DIG0 slot.
//  4. bcd1=0, bcd0=7:
//     - blank_lz=1 -> DIG1 slot an=11, seg=7F throughout.
//     - blank_lz=0 -> DIG1 shows seg=7'h40 (digit 0).
//  5. bcd0=4'hC -> units seg=7'h3F ("-"); err=1 and remains 1 after bcd0 returns to 3, until rst.
//  6. Drop en mid-slot for 5 clk:
//     - an=11, seg=7F from the next clk.
//     - On re-enable, the same slot completes its remaining count.
//     - Then assert rst mid-slot -> reset values on the next clk.

Source files
------------

// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed 7-segment driver with frame-coherent snapshot, anti-ghost blanking and LZ suppression.
// Latency: seg/an registered, 1 clk behind scan state; no backpressure (en=0 freezes scan, blanks display).
module bcd_7seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16,
    parameter int BLANK_CYC   = 1,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [6:0]       SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]       AN_OFF    = AN_ACT_LOW ? 2'b11 : 2'b00;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic             in_blank;
    logic [3:0]       snap0;
    logic [3:0]       snap1;
    logic             snap_lz;
    logic [3:0]       digit;
    logic [6:0]       seg_log;
    logic [1:0]       an_log;
    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;

    assign tick = en && (div_cnt == LAST);

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (div_cnt < BLANK_END);
        end
    endgenerate

    // Snapshot only when leaving the tens slot, so a whole frame shows one coherent value.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            snap0   <= '0;
            snap1   <= '0;
            snap_lz <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (en) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            if (tick && state == DIG1) begin
                snap0   <= bcd0;
                snap1   <= bcd1;
                snap_lz <= blank_lz;
            end
            if (snap0 > 4'd9 || snap1 > 4'd9) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIG0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            state_nxt = (state == DIG0) ? DIG1 : DIG0;
        end
    end

    always_comb begin
        digit  = (state == DIG1) ? snap1 : snap0;
        an_log = (state == DIG1) ? 2'b10 : 2'b01;
        if (!en || in_blank || (state == DIG1 && snap_lz && snap1 == 4'd0)) begin
            an_log = 2'b00;
        end
        case (digit)
            4'd0:    seg_log = 7'h3F;
            4'd1:    seg_log = 7'h06;
            4'd2:    seg_log = 7'h5B;
            4'd3:    seg_log = 7'h4F;
            4'd4:    seg_log = 7'h66;
            4'd5:    seg_log = 7'h6D;
            4'd6:    seg_log = 7'h7D;
            4'd7:    seg_log = 7'h07;
            4'd8:    seg_log = 7'h7F;
            4'd9:    seg_log = 7'h6F;
            default: seg_log = 7'h40;
        endcase
        if (an_log == 2'b00) begin
            seg_log = 7'h00;
        end
        seg_nxt = SEG_ACT_LOW ? ~seg_log : seg_log;
        an_nxt  = AN_ACT_LOW ? ~an_log : an_log;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with a 4-cycle slot and 1 blanking cycle, active-low pins.
module tb_bcd_7seg_scan;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan #(
        .REFRESH_DIV(4),
        .CNT_W      (16),
        .BLANK_CYC  (1),
        .SEG_ACT_LOW(1'b1),
        .AN_ACT_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .bcd0    (bcd0),
        .bcd1    (bcd1),
        .blank_lz(blank_lz),
        .seg     (seg),
        .an      (an),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cyc(input string tag, input logic [1:0] exp_an, input logic [6:0] exp_seg);
        step();
        check({tag, " an"}, 32'(an), 32'(exp_an));
        check({tag, " seg"}, 32'(seg), 32'(exp_seg));
    endtask

    // One slot: a blanking cycle, then three lit cycles.
    task automatic check_slot(input string tag, input logic [1:0] exp_an, input logic [6:0] exp_seg);
        check_cyc({tag, " blank"}, 2'b11, 7'h7F);
        for (int i = 0; i < 3; i++) begin
            check_cyc(tag, exp_an, exp_seg);
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        bcd0     = 4'd2;
        bcd1     = 4'd4;
        blank_lz = 1'b0;
        step();
        step();
        check("rst seg", 32'(seg), 32'h7F);
        check("rst an", 32'(an), 32'h3);
        check("rst err", 32'(err), 32'h0);

        rst = 1'b0;
        en  = 1'b1;
        // First frame shows the reset snapshot 00.
        check_slot("f0 units", 2'b10, 7'h40);
        check_slot("f0 tens", 2'b01, 7'h40);

        // 42 displayed; change units mid tens slot.
        check_slot("f1 units", 2'b10, 7'h24);
        check_cyc("f1 tens blank", 2'b11, 7'h7F);
        bcd0 = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check_cyc("f1 tens held", 2'b01, 7'h19);
        end
        check_slot("f2 units new", 2'b10, 7'h12);
        bcd1     = 4'd0;
        bcd0     = 4'd7;
        blank_lz = 1'b1;
        check_slot("f2 tens", 2'b01, 7'h19);

        // 07 with leading-zero blanking.
        check_slot("f3 units", 2'b10, 7'h78);
        blank_lz = 1'b0;
        check_slot("f3 tens lz", 2'b11, 7'h7F);

        // 07 without blanking.
        check_slot("f4 units", 2'b10, 7'h78);
        bcd0 = 4'hC;
        check_slot("f4 tens", 2'b01, 7'h40);
        check("err before", 32'(err), 32'h0);

        // Invalid units digit.
        check_slot("f5 units dash", 2'b10, 7'h3F);
        check("err set", 32'(err), 32'h1);
        bcd0 = 4'd3;
        check_slot("f5 tens", 2'b01, 7'h40);

        check_slot("f6 units", 2'b10, 7'h30);
        check("err sticky", 32'(err), 32'h1);
        check_slot("f6 tens", 2'b01, 7'h40);

        // Freeze scan mid units slot.
        check_cyc("f7 blank", 2'b11, 7'h7F);
        check_cyc("f7 units", 2'b10, 7'h30);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_cyc("en off", 2'b11, 7'h7F);
        end
        en = 1'b1;
        check_cyc("resume units", 2'b10, 7'h30);
        check_cyc("resume units last", 2'b10, 7'h30);
        check_cyc("resume tens blank", 2'b11, 7'h7F);
        check_cyc("resume tens", 2'b01, 7'h40);

        rst = 1'b1;
        step();
        check("rst2 seg", 32'(seg), 32'h7F);
        check("rst2 an", 32'(an), 32'h3);
        check("rst2 err", 32'(err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
